// File: rtl/cfg_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cfg_bank_pkg
// Description : Shared definitions for the configuration-bank arbiter:
//               register map, FSM state encoding and register reset value.
// Revision    : 1.0 - initial release
// ============================================================================
package cfg_bank_pkg;

    // Register map of the output/PWM configuration bank
    localparam int ADDR_OUT_LO = 0;   // output enables [7:0]
    localparam int ADDR_OUT_HI = 1;   // output enables [15:8]
    localparam int ADDR_PWM_LO = 2;   // PWM enables [7:0]
    localparam int ADDR_PWM_HI = 3;   // PWM enables [15:8]
    localparam int ADDR_DUTY   = 4;   // PWM duty cycle
    localparam int NUM_REGS    = 5;

    localparam logic [7:0] REG_RST_VAL = 8'h00;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/cfg_bank_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Purely combinational round-robin arbiter. Searches upward
//               from ptr_i (with wrap) and grants the first active request.
// Ports       : req_i      request vector
//               ptr_i      highest-priority index
//               gnt_o      one-hot grant
//               gnt_idx_o  binary index of the granted requester
//               any_o      at least one request active
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import cfg_bank_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0]   gnt_idx_o,
    output logic               any_o
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        idx       = '0;
        // Offset k = 0 is the pointer itself, so the first hit is the winner
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(ptr_i) + k) % NUM_REQ);
            if (!any_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
                any_o      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cfg_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cfg_bank_arbiter
// Description : Serialises writes from NUM_REQ requesters into the 5-register
//               output/PWM configuration bank with round-robin fairness and
//               drives the bank contents to the PWM/output stage.
//               Optional feature macro: CFG_SHADOW_EN (writes land in shadow
//               registers, copied to the live outputs on apply_i).
// Ports       : clk/rst                   clock, synchronous active-high reset
//               req_valid/ready/addr/data per-requester write handshake
//               apply_i                   shadow-to-live strobe
//               en_reg_* / pwm_duty_cycle live register outputs
//               busy_o, err_o, last_src_o status
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_bank_arbiter
    import cfg_bank_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic                       apply_i,
    output logic [7:0]                 en_reg_out_7_0,
    output logic [7:0]                 en_reg_out_15_8,
    output logic [7:0]                 en_reg_pwm_7_0,
    output logic [7:0]                 en_reg_pwm_15_8,
    output logic [7:0]                 pwm_duty_cycle,
    output logic                       busy_o,
    output logic                       err_o,
    output logic [$clog2(NUM_REQ)-1:0] last_src_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    src_q;
    logic [PTR_W-1:0]    last_src_q, last_src_d;
    logic [ADDR_W-1:0]   hold_addr_q;
    logic [DATA_W-1:0]   hold_data_q;

    logic [NUM_REQ-1:0]  gnt;
    logic [PTR_W-1:0]    gnt_idx;
    logic                gnt_any;
    logic                capture;
    logic                wr_en;
    logic                mapped;
    logic [NUM_REGS-1:0] sel;

    logic [DATA_W-1:0]   bank_q [NUM_REGS];
    logic [DATA_W-1:0]   bank_d [NUM_REGS];
    logic [DATA_W-1:0]   live   [NUM_REGS];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_o     (gnt_any)
    );

    // Full-width address decode: upper address bits must be zero to hit
    always_comb begin
        sel = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            sel[r] = (hold_addr_q == ADDR_W'(r));
        end
        mapped = |sel;
    end

    // ------------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        last_src_d = last_src_q;
        req_ready  = '0;
        capture    = 1'b0;
        wr_en      = 1'b0;
        busy_o     = 1'b0;
        err_o      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    req_ready = gnt;
                    capture   = 1'b1;
                    state_d   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                busy_o     = 1'b1;
                wr_en      = mapped;
                err_o      = !mapped;
                last_src_d = src_q;
                ptr_d      = (int'(src_q) == NUM_REQ - 1) ? '0 : src_q + 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            last_src_q  <= '0;
            src_q       <= '0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            last_src_q <= last_src_d;
            if (capture) begin
                src_q       <= gnt_idx;
                hold_addr_q <= req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
                hold_data_q <= req_data[int'(gnt_idx)*DATA_W +: DATA_W];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Written bank (shadow copy when the shadow feature is built, otherwise
    // the live registers themselves)
    // ------------------------------------------------------------------------
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            bank_d[r] = bank_q[r];
            if (wr_en && sel[r]) begin
                bank_d[r] = hold_data_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                bank_q[r] <= DATA_W'(REG_RST_VAL);
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                bank_q[r] <= bank_d[r];
            end
        end
    end

`ifdef CFG_SHADOW_EN
    logic [DATA_W-1:0] live_q [NUM_REGS];

    // Loading from bank_d forwards a write landing on the same edge as apply_i
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                live_q[r] <= DATA_W'(REG_RST_VAL);
            end
        end else if (apply_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                live_q[r] <= bank_d[r];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            live[r] = live_q[r];
        end
    end
`else
    logic apply_unused;
    assign apply_unused = apply_i;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            live[r] = bank_q[r];
        end
    end
`endif

    assign en_reg_out_7_0  = live[ADDR_OUT_LO];
    assign en_reg_out_15_8 = live[ADDR_OUT_HI];
    assign en_reg_pwm_7_0  = live[ADDR_PWM_LO];
    assign en_reg_pwm_15_8 = live[ADDR_PWM_HI];
    assign pwm_duty_cycle  = live[ADDR_DUTY];
    assign last_src_o      = last_src_q;

endmodule
`default_nettype wire
